// File: rtl/muldiv_writeback_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one bit per cycle, with a one-cycle register-file
// write pulse. Define MULDIV_EARLY_OUT_EN to skip the iterations for zero operands / zero divisor.
module muldiv_writeback_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WIDTH-1:0]    srcA,
  input  logic [WIDTH-1:0]    srcB,
  input  logic [REG_ADDR-1:0] destReg,
  output logic                busy,
  output logic                done,
  output logic                regWrite,
  output logic [REG_ADDR-1:0] writeReg,
  output logic [WIDTH-1:0]    writeData
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StWb} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [REG_ADDR-1:0] dest_q, dest_d;
  // opb: multiplicand for MUL*, divisor for DIV*
  logic [WIDTH-1:0]    opb_q, opb_d;
  // hi/lo: product high/low for MUL*, remainder/quotient for DIV*
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                regwrite_q, regwrite_d;
  logic [REG_ADDR-1:0] wreg_q, wreg_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;

  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      shifted;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dest_d     = dest_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;

    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d    = op;
          dest_d  = destReg;
          cnt_d   = CntW'(WIDTH - 1);
          state_d = StRun;
          hi_d    = '0;
          if (!op[1]) begin
            opb_d = srcA;
            lo_d  = srcB;
          end else begin
            opb_d = srcB;
            lo_d  = srcA;
          end
`ifdef MULDIV_EARLY_OUT_EN
          // Preload the final result so the WB path is shared with the iterative one.
          if (!op[1] && (srcA == '0 || srcB == '0)) begin
            hi_d    = '0;
            lo_d    = '0;
            state_d = StWb;
          end else if (op[1] && srcB == '0) begin
            hi_d    = srcA;
            lo_d    = '1;
            state_d = StWb;
          end
`endif
        end
      end
      StRun: begin
        if (!op_q[1]) begin
          hi_d = sum[WIDTH:1];
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else if (shifted >= {1'b0, opb_q}) begin
          hi_d = WIDTH'(shifted - {1'b0, opb_q});
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StWb;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered on the edge entering WB so they line up with the WB cycle.
    if (state_d == StWb) begin
      done_d     = 1'b1;
      regwrite_d = (dest_d != '0);
      wreg_d     = dest_d;
      wdata_d    = op_d[0] ? hi_d : lo_d;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign regWrite  = regwrite_q;
  assign writeReg  = wreg_q;
  assign writeData = wdata_q;

endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// Scoreboard bench for muldiv_writeback_unit: driver pushes expected writes, monitor checks them.
module tb_muldiv_writeback_unit;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  srcA = '0;
  logic [W-1:0]  srcB = '0;
  logic [4:0]    destReg = '0;
  logic          busy, done, regWrite;
  logic [4:0]    writeReg;
  logic [W-1:0]  writeData;

  muldiv_writeback_unit #(.WIDTH(W), .REG_ADDR(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .srcA      (srcA),
    .srcB      (srcB),
    .destReg   (destReg),
    .busy      (busy),
    .done      (done),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [4:0]  rd;
    logic [W-1:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   ign_busy = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit takes_early(input logic [1:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    return EarlyOut && (o[1] ? (b == 0) : (a == 0 || b == 0));
  endfunction

  // Wait for idle, present one request for one edge, and record the expected write.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] d, input bit expect_write);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_wait_busy", 32'(busy), 32'd0);
    start = 1'b1; op = o; srcA = a; srcB = b; destReg = d;
    @(posedge clk);
    #1;
    if (expect_write) begin
      e.due  = cyc + (takes_early(o, a, b) ? 0 : W);
      e.rd   = d;
      e.data = model(o, a, b);
      q.push_back(e);
    end
    start = 1'b0;
  endtask

  // Monitor: every negedge, compare outputs against the scoreboard head and held values.
  logic [4:0]   last_r = '0;
  logic [W-1:0] last_d = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        last_r = '0;
        last_d = '0;
      end else begin
        if (!ign_busy) chk("busy", 32'(busy), 32'(q.size() != 0));
        if (done) begin
          if (q.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.due));
            chk("writeReg", 32'(writeReg), 32'(e.rd));
            chk("writeData", writeData, e.data);
            chk("regWrite", 32'(regWrite), 32'(e.rd != 0));
            last_r = e.rd;
            last_d = e.data;
          end
        end else begin
          chk("regWrite_idle", 32'(regWrite), 32'd0);
          chk("writeData_hold", writeData, last_d);
          chk("writeReg_hold", 32'(writeReg), 32'(last_r));
          if (q.size() != 0 && cyc >= q[0].due) begin
            chk("missing_done", 32'(done), 32'd1);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    logic [4:0]   rd;
    int n;

    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_writeReg", 32'(writeReg), 32'd0);
    chk("rst_writeData", writeData, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Abort mid-run: no write may be issued
    issue(2'd0, 32'd7, 32'd6, 5'd3, 1'b0);
    ign_busy = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_regWrite", 32'(regWrite), 32'd0);
    chk("abort_writeData", writeData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ign_busy = 1'b0;

    issue(2'd0, 32'd7, 32'd6, 5'd5, 1'b1);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1);
    issue(2'd2, 32'd100, 32'd7, 5'd4, 1'b1);
    issue(2'd3, 32'd100, 32'd7, 5'd4, 1'b1);
    issue(2'd2, 32'h1234, 32'd0, 5'd6, 1'b1);
    issue(2'd3, 32'h1234, 32'd0, 5'd6, 1'b1);
    issue(2'd0, 32'd0, 32'd99, 5'd8, 1'b1);

    // Start pulse during RUN must be ignored
    issue(2'd0, 32'd123, 32'd456, 5'd7, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd2; srcA = 32'd9; srcB = 32'd3; destReg = 5'd9;
    @(negedge clk);
    start = 1'b0;

    // Write to register 0 is suppressed but done still pulses
    issue(2'd1, 32'd5, 32'd5, 5'd0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      rd = 5'($urandom_range(0, 31));
      issue(ro, ra, rb, rd, 1'b1);
    end

    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
